// File: rtl/partial_mem_pkg.sv
// Shared definitions for the data-memory partial load/store paths.
// Holds func3 encodings, the FSM state type and the alignment check.
package partial_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = F3_LB;
    localparam logic [2:0] F3_SH  = F3_LH;
    localparam logic [2:0] F3_SW  = F3_LW;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    // Size and alignment legality; unsigned variants share the size bits.
    function automatic logic access_ok(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic ok;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~a[0];
            F3_LW:         ok = (a == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the byte/half/word addressed by a load and extends it.
// Purely combinational; func3 selects width and signedness.
module load_extract
    import partial_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[8*addr +: 8];
    assign half_sel = rdata[16*addr[1] +: 16];

    always_comb begin
        data = rdata;
        case (func3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/partial_load_unit.sv
// Load path: one word-aligned memory read per request, then
// extracts/extends the addressed field and holds it until accepted.
module partial_load_unit
    import partial_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_fault
);

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  accept;
    logic                  legal;

    assign ld_ready   = (state_q == IDLE);
    assign mem_req    = (state_q == REQ);
    assign resp_valid = (state_q == RESP);
    assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign accept     = ld_ready & ld_valid;
    assign legal      = access_ok(func3, addr[1:0]);

    load_extract u_extract (
        .rdata (mem_rdata),
        .func3 (func3_q),
        .addr  (addr_q[1:0]),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = legal ? REQ : RESP;
            REQ:  if (mem_gnt) state_d = WAIT;
            WAIT: if (mem_rvalid) state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Illegal accesses skip memory and go straight to a fault response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            func3_q    <= '0;
            addr_q     <= '0;
            resp_data  <= '0;
            resp_fault <= 1'b0;
        end else if (accept) begin
            func3_q    <= func3;
            addr_q     <= addr;
            resp_data  <= '0;
            resp_fault <= ~legal;
        end else if (state_q == WAIT && mem_rvalid) begin
            resp_data  <= ext_data;
            resp_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_partial_load_unit.sv
// Directed bench for partial_load_unit with a scripted memory port.
// Expected results are hand-derived from the word 0x8899AABB.
module tb_partial_load_unit;
    import partial_mem_pkg::*;

    localparam logic [31:0] WORD = 32'h8899AABB;
    localparam logic [31:0] BASE = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    partial_load_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .func3      (func3),
        .addr       (addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_fault (resp_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Accept at edge T; with gnt_wait=0 the response is visible at T+3.
    task automatic run_load(input string tag, input logic [2:0] f3,
                            input logic [31:0] a, input int gnt_wait,
                            input int ready_wait, input logic [31:0] exp_d,
                            input logic exp_f);
        logic [31:0] a_word;
        a_word = {a[31:2], 2'b00};
        @(negedge clk);
        ld_valid = 1'b1;
        func3    = f3;
        addr     = a;
        check({tag, ".ld_ready"}, 32'(ld_ready), 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        func3    = 3'b111;
        addr     = 32'h0;
        if (exp_f) begin
            check({tag, ".no_req"}, 32'(mem_req), 32'd0);
        end else begin
            for (int i = 0; i < gnt_wait; i++) begin
                check({tag, ".req_hold"}, 32'(mem_req), 32'd1);
                check({tag, ".addr_hold"}, mem_addr, a_word);
                @(negedge clk);
            end
            check({tag, ".req"}, 32'(mem_req), 32'd1);
            check({tag, ".mem_addr"}, mem_addr, a_word);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            check({tag, ".req_drop"}, 32'(mem_req), 32'd0);
            check({tag, ".early_valid"}, 32'(resp_valid), 32'd0);
            mem_rvalid = 1'b1;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".resp_data"}, resp_data, exp_d);
        check({tag, ".resp_fault"}, 32'(resp_fault), 32'(exp_f));
        check({tag, ".busy"}, 32'(ld_ready), 32'd0);
        for (int i = 0; i < ready_wait; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_data"}, resp_data, exp_d);
            check({tag, ".hold_busy"}, 32'(ld_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, ".done"}, 32'(resp_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(ld_ready), 32'd1);
        if (exp_f) check({tag, ".no_req_end"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        ld_valid   = 1'b0;
        func3      = 3'b000;
        addr       = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = WORD;
        resp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.ld_ready", 32'(ld_ready), 32'd1);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_data", resp_data, 32'h0);
        check("rst.resp_fault", 32'(resp_fault), 32'd0);
        rst = 1'b1;

        run_load("lb",  F3_LB,  BASE + 1, 0, 0, 32'hFFFFFFAA, 1'b0);
        run_load("lbu", F3_LBU, BASE + 3, 0, 0, 32'h00000088, 1'b0);
        run_load("lhu", F3_LHU, BASE,     0, 0, 32'h0000AABB, 1'b0);
        run_load("lh",  F3_LH,  BASE + 2, 0, 0, 32'hFFFF8899, 1'b0);
        run_load("lw",  F3_LW,  BASE,     0, 0, 32'h8899AABB, 1'b0);
        run_load("lw_mis", F3_LW, BASE + 2, 0, 0, 32'h0, 1'b1);
        run_load("f3_011", 3'b011, BASE,    0, 0, 32'h0, 1'b1);
        run_load("lh_mis", F3_LH, BASE + 1, 0, 0, 32'h0, 1'b1);
        run_load("stall", F3_LW, BASE,      4, 3, 32'h8899AABB, 1'b0);

        // Reset while waiting for read data.
        @(negedge clk);
        ld_valid = 1'b1;
        func3    = F3_LW;
        addr     = BASE;
        @(negedge clk);
        ld_valid = 1'b0;
        mem_gnt  = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst     = 1'b0;
        #1;
        check("arst.ld_ready", 32'(ld_ready), 32'd1);
        check("arst.mem_req", 32'(mem_req), 32'd0);
        check("arst.mem_addr", mem_addr, 32'h0);
        check("arst.resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stale.resp_valid", 32'(resp_valid), 32'd0);
        check("stale.ld_ready", 32'(ld_ready), 32'd1);
        check("stale.mem_req", 32'(mem_req), 32'd0);
        run_load("after_rst", F3_LBU, BASE + 2, 0, 0, 32'h00000099, 1'b0);

        // Back-to-back with ld_valid held high throughout.
        @(negedge clk);
        ld_valid = 1'b1;
        func3    = F3_LB;
        addr     = BASE + 1;
        @(negedge clk);
        func3 = F3_LHU;
        addr  = BASE;
        check("b2b.addr1", mem_addr, BASE);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("b2b.data1", resp_data, 32'hFFFFFFAA);
        check("b2b.busy1", 32'(ld_ready), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("b2b.idle", 32'(ld_ready), 32'd1);
        check("b2b.no_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        check("b2b.req2", 32'(mem_req), 32'd1);
        check("b2b.addr2", mem_addr, BASE);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("b2b.valid2", 32'(resp_valid), 32'd1);
        check("b2b.data2", resp_data, 32'h0000AABB);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("b2b.done", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("b2b.single", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/partial_load_unit.md
Name: partial_load_unit

Overview:
Load-side counterpart of the data-memory partial store path in the npc core. Accepts one load request at a time from the LSU stage. Issues a word-aligned read to data memory over a req/gnt/rvalid port. Extracts the byte, half or word selected by func3 and the address low bits, sign- or zero-extends it to DATA_WIDTH, and holds the result until the core accepts it.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data and memory word width; fixed at 32.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ld_valid  in  1  load request valid
ld_ready  out  1  unit can accept a request (state IDLE)
func3  in  3  RV32I load func3, sampled on accept
addr  in  ADDR_WIDTH  byte address, sampled on accept
mem_req  out  1  memory read request
mem_addr  out  ADDR_WIDTH  word-aligned address, addr with [1:0] forced to 00
mem_gnt  in  1  memory accepted the request
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_WIDTH  read word
resp_valid  out  1  result valid
resp_ready  in  1  core accepts result
resp_data  out  DATA_WIDTH  extended load result; 0 when resp_fault
resp_fault  out  1  misaligned access or illegal func3

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ld_ready=1, mem_req=0, mem_addr=0, resp_valid=0, resp_data=0, resp_fault=0. Captured func3/addr cleared.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE → REQ on ld_valid&ld_ready when the access is legal. Capture func3 and addr.
- IDLE → RESP when the access is illegal: resp_fault=1, resp_data=0, mem_req never asserted.
- Illegal access:
  - func3 in {011,110,111}.
  - LH/LHU with addr[0]=1.
  - LW with addr[1:0]≠00.
- REQ: mem_req=1 with stable mem_addr until mem_gnt=1, then → WAIT. mem_req drops the cycle after gnt.
- WAIT: on mem_rvalid=1, register the extracted result into resp_data with resp_fault=0, then → RESP. mem_rvalid is ignored in every other state, including IDLE after reset, so stale data is dropped.
- RESP: resp_valid=1. resp_data and resp_fault are held stable until resp_ready=1, then → IDLE with resp_valid=0 the next cycle. No new accept in the same cycle as the handshake; ld_ready rises the cycle after.
- Memory protocol: rvalid arrives at least 1 cycle after gnt. Exactly one outstanding read.
- Minimum latency: accept at T, mem_req at T+1 (gnt same cycle), rvalid at T+2, resp_valid at T+3.
- Fault latency: resp_valid at T+1.
- Extraction:
  - byte = mem_rdata[8*a[1:0]+:8].
  - half = mem_rdata[16*a[1]+:16].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word.
- Mid-operation reset (any state): immediate return to reset values. No response is ever produced for the aborted load.
- Inputs other than mem_* are don't-care outside the states that sample them.

Decomposition:
- Shared package `partial_mem_pkg`:
  - func3 constants: F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101. The store path shares the SB/SH/SW encodings.
  - state enum {IDLE, REQ, WAIT, RESP}.
  - size/alignment-check helper function, reusable by the store path.
- One combinational sub-module, `load_extract`: inputs rdata, func3, addr[1:0]; output extended data. It has a separate unit bench.

Test Plan:
- Memory word at 0x80000000 = 0x8899AABB in all cases below.
- LB addr=0x80000001, gnt immediate, rvalid one cycle later → mem_addr=0x80000000, resp_data=0xFFFFFFAA, resp_fault=0, resp_valid at accept+3.
- LBU addr=0x80000003 → 0x00000088. LHU addr=0x80000000 → 0x0000AABB. LH addr=0x80000002 → 0xFFFF8899. LW addr=0x80000000 → 0x8899AABB.
- LW addr=0x80000002 → resp_fault=1, resp_data=0, resp_valid at accept+1, mem_req stays 0. Repeat with func3=011 → same fault response.
- mem_gnt held 0 for 4 cycles → mem_req and mem_addr stable; gnt on the 5th cycle. Then resp_ready held 0 for 3 cycles → resp_valid/resp_data stable, ld_ready=0 throughout, single completion.
- Assert rst=0 during WAIT. Then send a stale mem_rvalid in IDLE → no resp_valid. The next LBU at 0x80000002 returns 0x00000099.
- Back-to-back: ld_valid held high → second accept occurs only the cycle after the first resp handshake. Both results are correct and in order.
